// File: rtl/pseudo_spi_rx_intf_if.sv
// Bus bundle between the pseudo-SPI receive block (master modport) and its
// environment: start/config inputs, serial strobes and the SRAM write port.
interface pseudo_spi_rx_intf_if #(
    parameter int unsigned MEMORY_DATA_WIDTH = 8,
    parameter int unsigned MEMORY_ADDR_WIDTH = 9,
    parameter int unsigned RESERVED_DATA_LEN = 8
);
    logic                         BGN;
    logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN;
    logic [RESERVED_DATA_LEN-1:0] DATA_LEN;
    logic [7:0]                   FREQ_DIV;
    logic                         SPI_SI;
    logic                         SCLK1;
    logic                         SCLK2;
    logic                         LAT;
    logic [MEMORY_ADDR_WIDTH-1:0] A;
    logic [MEMORY_DATA_WIDTH-1:0] D;
    logic                         D_WE;
    logic                         is_i_addr;
    logic                         spi_is_done;
    logic                         PAR_ERR;

    modport master (
        input  BGN, ADDR_BGN, DATA_LEN, FREQ_DIV, SPI_SI,
        output SCLK1, SCLK2, LAT, A, D, D_WE, is_i_addr, spi_is_done, PAR_ERR
    );

    modport slave (
        output BGN, ADDR_BGN, DATA_LEN, FREQ_DIV, SPI_SI,
        input  SCLK1, SCLK2, LAT, A, D, D_WE, is_i_addr, spi_is_done, PAR_ERR
    );
endinterface

// File: rtl/pseudo_spi_rx_intf.sv
// Pseudo-SPI receive master: strobes an external scan chain and writes each byte to SRAM.
// Define PSEUDO_SPI_RX_PARITY_EN to add a 9th even-parity bit per byte and the sticky PAR_ERR flag.
module pseudo_spi_rx_intf #(
    parameter int unsigned MEMORY_DATA_WIDTH = 8,
    parameter int unsigned MEMORY_ADDR_WIDTH = 9,
    parameter int unsigned RESERVED_DATA_LEN = 8
) (
    input  logic                 CLK,
    input  logic                 rst,
    pseudo_spi_rx_intf_if.master bus
);
    localparam int unsigned DW = MEMORY_DATA_WIDTH;
    localparam int unsigned AW = MEMORY_ADDR_WIDTH;
    localparam int unsigned LW = RESERVED_DATA_LEN;
`ifdef PSEUDO_SPI_RX_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned NBITS = DW + PAR_BITS;
    localparam int unsigned BCW   = $clog2(NBITS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHFT, WRIT, LOOP, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    byte_idx_q, byte_idx_d;
    logic [7:0]       fdiv_q, fdiv_d;
    logic [7:0]       phase_cnt_q, phase_cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0] shift_q, shift_d;

    logic             sclk1_q, sclk1_d;
    logic             sclk2_q, sclk2_d;
    logic             lat_q, lat_d;
    logic [AW-1:0]    a_q, a_d;
    logic [DW-1:0]    d_q, d_d;
    logic             d_we_q, d_we_d;
    logic             is_i_addr_q, is_i_addr_d;
    logic             done_q, done_d;
    logic             par_err_q, par_err_d;

    logic             phase_end;
    logic [DW-1:0]    rx_byte;

    assign phase_end = (phase_cnt_q == fdiv_q);
    assign rx_byte   = shift_q[NBITS-1 -: DW];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        byte_idx_d  = byte_idx_q;
        fdiv_d      = fdiv_q;
        phase_cnt_d = phase_cnt_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;

        case (state_q)
            IDLE: begin
                if (bus.BGN) begin
                    addr_d      = bus.ADDR_BGN;
                    len_d       = bus.DATA_LEN;
                    fdiv_d      = bus.FREQ_DIV;
                    byte_idx_d  = '0;
                    phase_cnt_d = '0;
                    par_err_d   = 1'b0;
                    state_d     = (bus.DATA_LEN == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (phase_end) begin
                    phase_cnt_d = '0;
                    phase_d     = 2'd0;
                    bit_cnt_d   = '0;
                    state_d     = SHFT;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            SHFT: begin
                // Phases: 0 SCLK1 high, 1 gap, 2 SCLK2 high (sample at its end), 3 gap.
                if (phase_end) begin
                    phase_cnt_d = '0;
                    phase_d     = phase_q + 1'b1;
                    if (phase_q == 2'd2) begin
                        shift_d = {shift_q[NBITS-2:0], bus.SPI_SI};
                    end
                    if (phase_q == 2'd3) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BCW'(NBITS - 1)) begin
                            state_d = WRIT;
                        end
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            WRIT: begin
                state_d = LOOP;
`ifdef PSEUDO_SPI_RX_PARITY_EN
                if ((^rx_byte) != shift_q[0]) begin
                    par_err_d = 1'b1;
                end
`endif
            end
            LOOP: begin
                byte_idx_d = byte_idx_q + 1'b1;
                state_d    = (byte_idx_d == len_q) ? DONE : LOAD;
            end
            DONE: begin
                if (!bus.BGN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifndef PSEUDO_SPI_RX_PARITY_EN
        par_err_d = 1'b0;
`endif

        // Outputs are decoded from the next state so they stay registered yet line up with it.
        lat_d       = (state_d == LOAD);
        sclk1_d     = (state_d == SHFT) && (phase_d == 2'd0);
        sclk2_d     = (state_d == SHFT) && (phase_d == 2'd2);
        d_we_d      = (state_d == WRIT);
        is_i_addr_d = (state_d == LOAD) || (state_d == SHFT) ||
                      (state_d == WRIT) || (state_d == LOOP);
        done_d      = (state_d == DONE);
        a_d         = a_q;
        d_d         = d_q;
        if (state_d == WRIT) begin
            a_d = addr_q + AW'(byte_idx_q);
            d_d = rx_byte;
        end
        if (state_d == IDLE) begin
            a_d = '0;
            d_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            byte_idx_q  <= '0;
            fdiv_q      <= '0;
            phase_cnt_q <= '0;
            phase_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            sclk1_q     <= 1'b0;
            sclk2_q     <= 1'b0;
            lat_q       <= 1'b0;
            a_q         <= '0;
            d_q         <= '0;
            d_we_q      <= 1'b0;
            is_i_addr_q <= 1'b0;
            done_q      <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            byte_idx_q  <= byte_idx_d;
            fdiv_q      <= fdiv_d;
            phase_cnt_q <= phase_cnt_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sclk1_q     <= sclk1_d;
            sclk2_q     <= sclk2_d;
            lat_q       <= lat_d;
            a_q         <= a_d;
            d_q         <= d_d;
            d_we_q      <= d_we_d;
            is_i_addr_q <= is_i_addr_d;
            done_q      <= done_d;
            par_err_q   <= par_err_d;
        end
    end

    assign bus.SCLK1       = sclk1_q;
    assign bus.SCLK2       = sclk2_q;
    assign bus.LAT         = lat_q;
    assign bus.A           = a_q;
    assign bus.D           = d_q;
    assign bus.D_WE        = d_we_q;
    assign bus.is_i_addr   = is_i_addr_q;
    assign bus.spi_is_done = done_q;
    assign bus.PAR_ERR     = par_err_q;
endmodule

// File: tb/tb_pseudo_spi_rx_intf.sv
// Scoreboard bench for pseudo_spi_rx_intf: an external shift-register model feeds SPI_SI,
// expected SRAM writes are queued at stimulus time and popped by a D_WE monitor.
module tb_pseudo_spi_rx_intf;
`ifdef PSEUDO_SPI_RX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic CLK = 1'b0;
    logic rst;
    always #5 CLK = ~CLK;

    pseudo_spi_rx_intf_if bif ();

    pseudo_spi_rx_intf #(
        .MEMORY_DATA_WIDTH(8),
        .MEMORY_ADDR_WIDTH(9),
        .RESERVED_DATA_LEN(8)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bif)
    );

    typedef struct {
        logic [8:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [8:0] tx_q[$];
    int         checks = 0;
    int         errors = 0;
    int         lat_cnt = 0;
    int         we_cnt = 0;
    int         s1_run, s2_run, s1_min, s1_max, s2_min, s2_max, p_min, p_max, since_rise;
    bit         rise_valid;
    logic       prev_lat, prev_s1, prev_s2, prev_we;
    wr_t        mon_e;

    // External scan chain: loads a word on LAT, presents one bit per SCLK1 pulse, MSB first.
    logic [8:0] drv_cur;
    int         drv_pos;
    logic       drv_prev_lat, drv_prev_s1;
    always @(negedge CLK) begin
        if (rst) begin
            drv_cur      = 9'h0;
            drv_pos      = 0;
            drv_prev_lat = 1'b0;
            drv_prev_s1  = 1'b0;
            bif.SPI_SI   = 1'b0;
        end else begin
            if (bif.LAT && !drv_prev_lat) begin
                drv_cur = (tx_q.size() > 0) ? tx_q.pop_front() : 9'h0;
                drv_pos = 0;
            end
            if (bif.SCLK1 && !drv_prev_s1 && drv_pos < 9) begin
                bif.SPI_SI = drv_cur[8-drv_pos];
                drv_pos++;
            end
            drv_prev_lat = bif.LAT;
            drv_prev_s1  = bif.SCLK1;
        end
    end

    always @(negedge CLK) begin
        if (rst) begin
            prev_lat = 1'b0; prev_s1 = 1'b0; prev_s2 = 1'b0; prev_we = 1'b0;
            s1_run = 0; s2_run = 0; since_rise = 0; rise_valid = 1'b0;
        end else begin
            if (bif.D_WE) begin
                we_cnt++;
                checks++;
                if (prev_we) begin
                    errors++;
                    $display("FAIL we_pulse: D_WE high for 2+ cycles, required single cycle");
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: A=%0d D=%02h, required no write", bif.A, bif.D);
                end else begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    if (bif.A !== mon_e.addr || bif.D !== mon_e.data) begin
                        errors++;
                        $display("FAIL sram_write: A=%0d D=%02h, required A=%0d D=%02h",
                                 bif.A, bif.D, mon_e.addr, mon_e.data);
                    end
                end
            end
            if (bif.SCLK1 || bif.SCLK2) begin
                checks++;
                if (bif.SCLK1 && bif.SCLK2) begin
                    errors++;
                    $display("FAIL sclk_overlap: SCLK1=1 SCLK2=1, required never both 1");
                end
            end
            if (bif.SCLK1) s1_run++;
            else if (s1_run > 0) begin
                if (s1_run < s1_min) s1_min = s1_run;
                if (s1_run > s1_max) s1_max = s1_run;
                s1_run = 0;
            end
            if (bif.SCLK2) s2_run++;
            else if (s2_run > 0) begin
                if (s2_run < s2_min) s2_min = s2_run;
                if (s2_run > s2_max) s2_max = s2_run;
                s2_run = 0;
            end
            if (bif.LAT) rise_valid = 1'b0;
            since_rise++;
            if (bif.SCLK1 && !prev_s1) begin
                if (rise_valid) begin
                    if (since_rise < p_min) p_min = since_rise;
                    if (since_rise > p_max) p_max = since_rise;
                end
                rise_valid = 1'b1;
                since_rise = 0;
            end
            if (bif.LAT && !prev_lat) lat_cnt++;
            prev_lat = bif.LAT;
            prev_s1  = bif.SCLK1;
            prev_s2  = bif.SCLK2;
            prev_we  = bif.D_WE;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    function automatic logic [23:0] outs();
        return {bif.SCLK1, bif.SCLK2, bif.LAT, bif.A, bif.D, bif.D_WE,
                bif.is_i_addr, bif.spi_is_done, bif.PAR_ERR};
    endfunction

    task automatic push_byte(input logic [8:0] addr, input logic [7:0] data,
                             input logic par, input bit expect_write);
        wr_t w;
        tx_q.push_back({data, par});
        if (expect_write) begin
            w.addr = addr;
            w.data = data;
            exp_q.push_back(w);
        end
    endtask

    task automatic stats_clear();
        s1_min = 1000; s1_max = 0; s2_min = 1000; s2_max = 0; p_min = 1000; p_max = 0;
    endtask

    task automatic run_xfer(input string nm, input logic [8:0] ab, input logic [7:0] len,
                            input logic [7:0] fd, input logic [8:0] last_a, input bit fd_glitch);
        int n;
        bit got;
        int exp_n;
        exp_n = 1 + int'(len) * ((int'(fd) + 1) * (1 + 4 * NB) + 2);
        @(negedge CLK);
        bif.ADDR_BGN = ab;
        bif.DATA_LEN = len;
        bif.FREQ_DIV = fd;
        lat_cnt = 0;
        we_cnt = 0;
        bif.BGN = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 20000) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            got = bif.spi_is_done;
            if (fd_glitch && n == 2) bif.FREQ_DIV = 8'd0;
        end
        check({nm, "_latency"}, n, exp_n);
        check({nm, "_lat_pulses"}, lat_cnt, int'(len));
        check({nm, "_we_pulses"}, we_cnt, int'(len));
        check({nm, "_pending_writes"}, exp_q.size(), 0);
        check({nm, "_done_addr"}, bif.A, last_a);
        repeat (2) @(negedge CLK);
        check({nm, "_done_hold"}, bif.spi_is_done, 1);
        bif.BGN = 1'b0;
        @(negedge CLK);
        check({nm, "_done_clear"}, bif.spi_is_done, 0);
        check({nm, "_idle_owner"}, bif.is_i_addr, 0);
    endtask

    logic [7:0] basic [14];
    int         n, k;
    logic       prev;

    initial begin
        basic = '{8'hAB, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h05, 8'h3D,
                  8'h9E, 8'hC3, 8'hD7, 8'h58, 8'h7A, 8'h01, 8'hC2};
        rst = 1'b1;
        bif.BGN = 1'b0;
        bif.ADDR_BGN = '0;
        bif.DATA_LEN = '0;
        bif.FREQ_DIV = '0;
        stats_clear();
        repeat (3) @(negedge CLK);
        check("reset_outputs", outs(), 24'h0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("idle_outputs", outs(), 24'h0);
        end

        run_xfer("len0", 9'd77, 8'd0, 8'd0, 9'd0, 1'b0);

        for (int i = 0; i < 14; i++) push_byte(9'd32 + 9'(i), basic[i], ^basic[i], 1'b1);
        run_xfer("basic", 9'd32, 8'd14, 8'd0, 9'd45, 1'b0);
        check("basic_par_err", bif.PAR_ERR, 0);

        stats_clear();
        push_byte(9'd7, 8'h5A, 1'b0, 1'b1);
        run_xfer("shape", 9'd7, 8'd1, 8'd3, 9'd7, 1'b1);
        check("sclk1_min_high", s1_min, 4);
        check("sclk1_max_high", s1_max, 4);
        check("sclk2_min_high", s2_min, 4);
        check("sclk2_max_high", s2_max, 4);
        check("bit_period_min", p_min, 16);
        check("bit_period_max", p_max, 16);

        push_byte(9'd510, 8'h81, 1'b0, 1'b1);
        push_byte(9'd511, 8'h42, 1'b0, 1'b1);
        push_byte(9'd0,   8'hE7, 1'b0, 1'b1);
        run_xfer("wrap", 9'd510, 8'd3, 8'd0, 9'd0, 1'b0);

        push_byte(9'd100, 8'h11, 1'b0, 1'b1);
        push_byte(9'd101, 8'h22, 1'b0, 1'b0);
        push_byte(9'd102, 8'h33, 1'b0, 1'b0);
        @(negedge CLK);
        bif.ADDR_BGN = 9'd100;
        bif.DATA_LEN = 8'd3;
        bif.FREQ_DIV = 8'd0;
        we_cnt = 0;
        bif.BGN = 1'b1;
        n = 0;
        while (we_cnt < 1 && n < 2000) begin @(negedge CLK); n++; end
        n = 0; k = 0; prev = 1'b0;
        while (k < 5 && n < 2000) begin
            @(negedge CLK);
            n++;
            if (bif.SCLK2 && !prev) k++;
            prev = bif.SCLK2;
        end
        check("midrst_bits_seen", k, 5);
        #1 rst = 1'b1;
        bif.BGN = 1'b0;
        #1 check("midrst_outputs", outs(), 24'h0);
        repeat (3) @(negedge CLK);
        tx_q.delete();
        rst = 1'b0;
        repeat (10) @(negedge CLK);
        check("midrst_idle", outs(), 24'h0);
        check("midrst_writes", we_cnt, 1);
        push_byte(9'd100, 8'h11, 1'b0, 1'b1);
        push_byte(9'd101, 8'h22, 1'b0, 1'b1);
        push_byte(9'd102, 8'h33, 1'b0, 1'b1);
        run_xfer("restart", 9'd100, 8'd3, 8'd0, 9'd102, 1'b0);

`ifdef PSEUDO_SPI_RX_PARITY_EN
        push_byte(9'd200, 8'hA5, 1'b1, 1'b1);
        run_xfer("par_bad", 9'd200, 8'd1, 8'd0, 9'd200, 1'b0);
        check("par_err_set", bif.PAR_ERR, 1);
        push_byte(9'd200, 8'hA5, 1'b0, 1'b1);
        run_xfer("par_good", 9'd200, 8'd1, 8'd0, 9'd200, 1'b0);
        check("par_err_cleared", bif.PAR_ERR, 0);
`endif

        repeat (3) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pseudo_spi_rx_intf.md
Name: pseudo_spi_rx_intf

Overview:
- Receive-direction counterpart of the pseudo-SPI transmit interface.
- Acts as serial master: generates the two-phase scan clocks SCLK1/SCLK2 and the load strobe LAT, and samples SPI_SI MSB-first.
- Assembles each 8-bit byte and writes it into the 512x8 SRAM from ADDR_BGN onward, for DATA_LEN bytes.
- Used to load instruction/data images into SRAM from an external scan chain before the CPU runs.

Parameters:
- MEMORY_DATA_WIDTH, 8, SRAM word width and bits per received byte.
- MEMORY_ADDR_WIDTH, 9, SRAM address width.
- RESERVED_DATA_LEN, 8, width of the DATA_LEN byte counter.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- BGN  input  1  level enable; transfer starts when sampled high in IDLE.
- ADDR_BGN  input  9  first SRAM write address.
- DATA_LEN  input  8  number of bytes to receive.
- FREQ_DIV  input  8  phase length = FREQ_DIV+1 CLK cycles.
- SPI_SI  input  1  serial data in.
- SCLK1  output  1  scan clock phase 1.
- SCLK2  output  1  scan clock phase 2 (never overlaps SCLK1).
- LAT  output  1  parallel-load strobe to the external shift register, once per byte.
- A  output  9  SRAM address.
- D  output  8  SRAM write data.
- D_WE  output  1  SRAM write enable, 1 = write.
- is_i_addr  output  1  high while the block owns the SRAM address bus.
- spi_is_done  output  1  transfer complete.
- PAR_ERR  output  1  sticky parity error (see Optional Feature).

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- States: IDLE -> LOAD -> SHFT -> WRIT -> (LOOP -> LOAD | DONE).
- IDLE:
  - With BGN=1 and DATA_LEN!=0: go to LOAD, latch ADDR_BGN/DATA_LEN/FREQ_DIV, clear PAR_ERR.
  - With BGN=1 and DATA_LEN=0: go directly to DONE; no strobes, no writes.
- LAT and is_i_addr:
  - LOAD: LAT=1 for FREQ_DIV+1 cycles, then SHFT.
  - is_i_addr=1 in LOAD/SHFT/WRIT/LOOP.
- SHFT, per bit: four phases of FREQ_DIV+1 cycles each: SCLK1=1, gap, SCLK2=1, gap.
  - SPI_SI is sampled on the CLK edge ending the SCLK2-high phase and shifted in at the LSB (first bit ends as MSB).
  - Bit period = 4*(FREQ_DIV+1) cycles.
- WRIT: single cycle; D_WE=1, A=ADDR_BGN+byte_index (mod 512, wraps 511->0), D=assembled byte. D_WE is 0 in all other states.
- LOOP: single cycle; increment byte_index; if byte_index==DATA_LEN go to DONE, else LOAD.
- Latency: one byte = (FREQ_DIV+1)*(1+4*8) + 2 cycles.
- DONE: spi_is_done=1, A holds last address; remain while BGN=1; BGN=0 -> IDLE, spi_is_done=0 next cycle.
- BGN dropped mid-transfer: ignored; transfer completes.
- rst mid-transfer: immediate abort to IDLE, outputs 0; no partial byte is written.
- FREQ_DIV changes mid-transfer: no effect; the value latched at start is used.

Optional Feature:
- Macro: PSEUDO_SPI_RX_PARITY_EN.
- Defined:
  - Each byte is followed by a 9th bit period carrying even parity over the 8 data bits.
  - On mismatch, PAR_ERR sets and stays set until the next transfer start or rst.
  - The byte is still written.
  - Byte latency gains 4*(FREQ_DIV+1) cycles.
- Undefined: 8 bits per byte; PAR_ERR tied 0.

Test Plan:
- Reset/idle: rst pulse, BGN=0 -> all outputs 0 for 20 cycles.
- Basic load: ADDR_BGN=32, DATA_LEN=14, FREQ_DIV=0, bench model shifts bytes AB,00,00,3C,00,05,3D,9E,C3,D7,58,7A,01,C2 MSB-first on SCLK2 -> SRAM[32..45] match exactly; 14 single-cycle D_WE pulses; spi_is_done after 14*35 cycles; 14 LAT pulses.
- Clock shape: FREQ_DIV=3 -> each SCLK1/SCLK2 high exactly 4 cycles, 16-cycle bit period, SCLK1&SCLK2 never both 1.
- Boundaries:
  - DATA_LEN=0 -> spi_is_done=1 one cycle after BGN, no D_WE.
  - ADDR_BGN=510, DATA_LEN=3 -> writes to 510, 511, 0.
- Reset mid-byte: assert rst after 5 bits of byte 2 -> no write for byte 2; outputs 0; a restart with BGN re-runs from ADDR_BGN cleanly.
- Parity (macro defined): byte 8'hA5 with parity bit 1 -> PAR_ERR=1, SRAM still holds A5; next BGN start clears PAR_ERR. Correct parity 0 -> PAR_ERR stays 0.
